// File: rtl/w4823_fir_feeder.sv
// w4823_fir_feeder: loads FIR coefficients, paces samples into the FIR and
// captures its results while tracking outstanding samples.
module w4823_fir_feeder #(
  parameter int NTAPS      = 64,
  parameter int SAMPLE_GAP = 4,
  parameter int OUTST_W    = 8
) (
  input  logic                      clk1,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [16:0]               hc_data,
  input  logic                      hc_valid,
  output logic                      hc_ready,
  input  logic [15:0]               hs_data,
  input  logic                      hs_valid,
  output logic                      hs_ready,
  output logic [16:0]               cin,
  output logic [$clog2(NTAPS)-1:0]  caddr,
  output logic                      cload,
  output logic [15:0]               din,
  output logic                      valid_in,
  input  logic [15:0]               dout,
  input  logic                      valid,
  output logic [15:0]               res_data,
  output logic                      res_valid,
  output logic                      coef_loaded,
  output logic                      busy,
  output logic                      err_unexp,
  output logic [OUTST_W-1:0]        outstanding
);
  localparam int AW = $clog2(NTAPS);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] k_q;
  logic [7:0] g_q;
  logic hc_acc, hs_acc, last_coef;
  logic [OUTST_W-1:0] outst_d;
  assign busy      = state_q != IDLE;
  assign hc_ready  = state_q == LOAD;
  assign hs_ready  = state_q == RUN && g_q == 8'd0 && !cfg_stop && outstanding != '1;
  assign hc_acc    = hc_valid && hc_ready && !cfg_stop;
  assign hs_acc    = hs_valid && hs_ready;
  assign last_coef = hc_acc && k_q == AW'(NTAPS - 1);
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (cfg_start ? LOAD : IDLE) :
              cfg_stop ? IDLE : last_coef ? RUN : state_q;
  end
  // a simultaneous sample accept and result cancel out
  always_comb begin
    outst_d = outstanding;
    outst_d = (hs_acc && !valid) ? outstanding + 1'b1 :
              (valid && !hs_acc && outstanding != '0) ? outstanding - 1'b1 : outstanding;
  end
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      g_q         <= '0;
      cin         <= '0;
      caddr       <= '0;
      cload       <= 1'b0;
      din         <= '0;
      valid_in    <= 1'b0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      coef_loaded <= 1'b0;
      err_unexp   <= 1'b0;
      outstanding <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cfg_start) begin
        k_q         <= '0;
        coef_loaded <= 1'b0;
      end
      if (hc_acc) begin
        cin   <= hc_data;
        caddr <= k_q;
        k_q   <= k_q + 1'b1;
      end
      if (last_coef) coef_loaded <= 1'b1;
      cload    <= hc_acc;
      valid_in <= hs_acc;
      if (hs_acc) din <= hs_data;
      g_q <= hs_acc ? 8'(SAMPLE_GAP - 1) : (g_q != 8'd0 ? g_q - 1'b1 : g_q);
      res_valid <= valid;
      if (valid) res_data <= dout;
      if (valid && outstanding == '0) err_unexp <= 1'b1;
      outstanding <= outst_d;
    end
  end
endmodule

// File: tb/tb_w4823_fir_feeder.sv
// tb_w4823_fir_feeder: randomized scoreboard bench; a transaction-level model
// predicts strobes into queues that a posedge monitor pops and compares.
module tb_w4823_fir_feeder;
  localparam int GAP = 4;
  logic clk1 = 1'b0, rst_n;
  logic cfg_start, cfg_stop, hc_valid, hc_ready, hs_valid, hs_ready;
  logic [16:0] hc_data, cin;
  logic [15:0] hs_data, din, dout, res_data;
  logic [5:0] caddr;
  logic cload, valid_in, valid, res_valid, coef_loaded, busy, err_unexp;
  logic [7:0] outstanding;
  w4823_fir_feeder #(.NTAPS(64), .SAMPLE_GAP(GAP), .OUTST_W(8)) dut (
    .clk1(clk1), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .hc_data(hc_data), .hc_valid(hc_valid), .hc_ready(hc_ready),
    .hs_data(hs_data), .hs_valid(hs_valid), .hs_ready(hs_ready),
    .cin(cin), .caddr(caddr), .cload(cload), .din(din), .valid_in(valid_in),
    .dout(dout), .valid(valid), .res_data(res_data), .res_valid(res_valid),
    .coef_loaded(coef_loaded), .busy(busy), .err_unexp(err_unexp),
    .outstanding(outstanding));
  always #5 clk1 = ~clk1;
  int checks = 0, errors = 0;
  logic [22:0] cq[$];
  logic [15:0] dq[$], rq[$];
  int m_state = 0, m_k = 0, m_outst = 0, m_next = 0, cyc = 0;
  bit m_loaded = 0, m_err = 0, m_rst = 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // model: state 0 idle, 1 load, 2 run; samples allowed GAP cycles apart
  task automatic step();
    bit hc_acc, hs_acc, rdy;
    #1;
    if (!rst_n) begin
      m_state = 0; m_k = 0; m_outst = 0; m_next = 0;
      m_loaded = 0; m_err = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      rdy = m_state == 2 && cyc >= m_next && !cfg_stop && m_outst < 255;
      chk("hc_ready", hc_ready, m_state == 1);
      chk("hs_ready", hs_ready, rdy);
      hc_acc = m_state == 1 && hc_valid && !cfg_stop;
      hs_acc = rdy && hs_valid;
      if (hc_acc) begin cq.push_back({6'(m_k), hc_data}); m_k++; end
      if (hs_acc) begin dq.push_back(hs_data); m_next = cyc + GAP; end
      if (valid) begin rq.push_back(dout); if (m_outst == 0) m_err = 1; end
      if (hs_acc && !valid) m_outst++;
      else if (valid && !hs_acc && m_outst > 0) m_outst--;
      if (m_state == 0 && cfg_start) begin m_state = 1; m_k = 0; m_loaded = 0; end
      else if (m_state != 0 && cfg_stop) m_state = 0;
      else if (m_state == 1 && m_k == 64) begin m_state = 2; m_loaded = 1; end
    end
    cyc++;
    @(posedge clk1);
    #2;
  endtask
  logic [22:0] ce;
  logic [15:0] de, re;
  always @(posedge clk1) begin
    #1;
    if (m_rst) begin
      chk("rst_cin", cin, 0); chk("rst_caddr", caddr, 0); chk("rst_din", din, 0);
      chk("rst_res_data", res_data, 0); chk("rst_cload", cload, 0);
      chk("rst_valid_in", valid_in, 0); chk("rst_res_valid", res_valid, 0);
    end
    if (cload) begin
      if (cq.size() == 0) begin
        checks++; errors++; $display("FAIL cload: got pulse expected none");
      end else begin
        ce = cq.pop_front();
        chk("caddr", caddr, ce[22:17]);
        chk("cin", cin, ce[16:0]);
      end
    end
    if (valid_in) begin
      if (dq.size() == 0) begin
        checks++; errors++; $display("FAIL valid_in: got pulse expected none");
      end else begin
        de = dq.pop_front();
        chk("din", din, de);
      end
    end
    if (res_valid) begin
      if (rq.size() == 0) begin
        checks++; errors++; $display("FAIL res_valid: got pulse expected none");
      end else begin
        re = rq.pop_front();
        chk("res_data", res_data, re);
      end
    end
    chk("busy", busy, m_state != 0);
    chk("coef_loaded", coef_loaded, m_loaded);
    chk("err_unexp", err_unexp, m_err);
    chk("outstanding", outstanding, m_outst);
  end
  initial begin
    int n;
    {cfg_start, cfg_stop, hc_valid, hs_valid, valid} = '0;
    hc_data = '0; hs_data = '0; dout = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    cfg_start = 1; step(); cfg_start = 0;
    for (int i = 0; i < 64; i++) begin
      hc_valid = 1; hc_data = 17'(i); cfg_start = (i == 20); step();
    end
    hc_valid = 0; cfg_start = 0;
    for (int i = 0; i < 17; i++) begin
      hs_valid = 1; hs_data = 16'h3C00 + 16'(i) * 16'h0400; step();
    end
    hs_valid = 0;
    dout = 16'h1234; valid = 1; step(); valid = 0; step();
    dout = 16'h5678; valid = 1; step(); valid = 0; step();
    dout = 16'h9ABC; valid = 1; step(); valid = 0; step();
    for (int i = 0; i < 300; i++) begin
      hs_valid = 1'($urandom % 2); hs_data = 16'($urandom);
      valid = m_outst > 0 && ($urandom % 3 == 0); dout = 16'($urandom);
      step();
    end
    valid = 0; hs_valid = 1; n = 0;
    while (m_outst < 255 && n < 1500) begin hs_data = 16'($urandom); step(); n++; end
    chk("saturated", outstanding, 255);
    repeat (6) step();
    hs_valid = 0; n = 0;
    while (m_outst > 0 && n < 400) begin valid = 1; dout = 16'($urandom); step(); n++; end
    valid = 0; step();
    chk("drained", outstanding, 0);
    dout = 16'hBEEF; valid = 1; step(); valid = 0; step();
    chk("err_after_extra", err_unexp, 1);
    cfg_stop = 1; step(); cfg_stop = 0; step();
    cfg_start = 1; step(); cfg_start = 0; n = 0;
    while (m_k < 10 && n < 200) begin
      hc_valid = 1'($urandom % 2); hc_data = 17'($urandom); step(); n++;
    end
    hc_valid = 1; cfg_stop = 1; step();
    hc_valid = 0; cfg_stop = 0;
    repeat (4) step();
    chk("abort_loaded", coef_loaded, 0);
    cfg_start = 1; step(); cfg_start = 0; n = 0;
    while (m_state == 1 && n < 400) begin
      hc_valid = 1'($urandom % 2); hc_data = 17'($urandom); step(); n++;
    end
    hc_valid = 0;
    chk("reload_run", busy, 1);
    for (int i = 0; i < 30; i++) begin
      hs_valid = 1'($urandom % 2); hs_data = 16'($urandom);
      valid = m_outst > 0 && ($urandom % 2 == 0); dout = 16'($urandom);
      step();
    end
    hs_valid = 1; valid = 1; rst_n = 0; step();
    hs_valid = 0; valid = 0; rst_n = 1;
    repeat (4) step();
    chk("cq_empty", cq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
